// File: rtl/otter_hazard_pkg.sv
// Shared types for the OTTER hazard unit: forwarding select codes and
// stall-controller states.
package otter_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2,
        FWD_RSVD = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int unsigned SEL_W = 2;

endpackage

// File: rtl/otter_fwd_sel.sv
// Forwarding select for one ALU source operand. EX/MEM beats MEM/WB, and
// writes to x0 are never forwarded.
module otter_fwd_sel
    import otter_hazard_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] rs_i,
    input  logic              rs_used_i,
    input  logic [ADDR_W-1:0] ex_mem_rd_i,
    input  logic              ex_mem_regwrite_i,
    input  logic [ADDR_W-1:0] mem_wb_rd_i,
    input  logic              mem_wb_regwrite_i,
    output logic [SEL_W-1:0]  sel_o
);

    logic hit_mem;
    logic hit_wb;

    assign hit_mem = rs_used_i && ex_mem_regwrite_i && (ex_mem_rd_i != '0)
                     && (ex_mem_rd_i == rs_i);
    assign hit_wb  = rs_used_i && mem_wb_regwrite_i && (mem_wb_rd_i != '0)
                     && (mem_wb_rd_i == rs_i);

    always_comb begin
        sel_o = FWD_RF;
        if (hit_mem) begin
            sel_o = FWD_MEM;
        end else if (hit_wb) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/otter_hazard_unit.sv
// OTTER hazard controller: operand forwarding selects, load-use and memory-wait
// stall sequencing, saturating stall counters and a sticky memory watchdog.
module otter_hazard_unit
    import otter_hazard_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [NUM_SRC*ADDR_W-1:0] RS,
    input  logic [NUM_SRC-1:0]        RS_USED,
    input  logic [NUM_SRC*ADDR_W-1:0] IF_ID_RS,
    input  logic [NUM_SRC-1:0]        IF_ID_RS_USED,
    input  logic [ADDR_W-1:0]         ID_EX_RD,
    input  logic                      ID_EX_MEMREAD,
    input  logic [ADDR_W-1:0]         EX_MEM_RD,
    input  logic                      EX_MEM_REGWRITE,
    input  logic                      EX_MEM_MEMREAD,
    input  logic [ADDR_W-1:0]         MEM_WB_RD,
    input  logic                      MEM_WB_REGWRITE,
    input  logic                      DMEM_RSP_VALID,
    input  logic                      FLUSH,
    input  logic                      ERR_CLR,
    input  logic                      CNT_CLR,
    output logic [NUM_SRC*SEL_W-1:0]  SEL,
    output logic                      STALL_FE,
    output logic                      BUBBLE_EX,
    output logic                      STALL_BE,
    output logic                      BUBBLE_WB,
    output logic [CNT_W-1:0]          CNT_LU,
    output logic [CNT_W-1:0]          CNT_MEM,
    output logic                      ERR_TIMEOUT
);

    // Wide enough to hold TIMEOUT so a long wait parks instead of wrapping.
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    hz_state_t             state_q, state_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]      cnt_lu_q, cnt_lu_d;
    logic [CNT_W-1:0]      cnt_mem_q, cnt_mem_d;
    logic                  err_q, err_d;

    logic [NUM_SRC*SEL_W-1:0] sel_raw;
    logic                     mem_wait;
    logic                     lu_match;
    logic                     lu;
    logic                     lu_stall;
    logic                     stall_fe;
    logic                     bubble_ex;
    logic                     stall_be;
    logic                     bubble_wb;

    for (genvar n = 0; n < NUM_SRC; n++) begin : g_fwd
        otter_fwd_sel #(
            .ADDR_W(ADDR_W)
        ) u_fwd_sel (
            .rs_i             (RS[n*ADDR_W +: ADDR_W]),
            .rs_used_i        (RS_USED[n]),
            .ex_mem_rd_i      (EX_MEM_RD),
            .ex_mem_regwrite_i(EX_MEM_REGWRITE),
            .mem_wb_rd_i      (MEM_WB_RD),
            .mem_wb_regwrite_i(MEM_WB_REGWRITE),
            .sel_o            (sel_raw[n*SEL_W +: SEL_W])
        );
    end

    assign mem_wait = EX_MEM_MEMREAD && !DMEM_RSP_VALID;

    always_comb begin
        lu_match = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (IF_ID_RS_USED[n] && (IF_ID_RS[n*ADDR_W +: ADDR_W] == ID_EX_RD)) begin
                lu_match = 1'b1;
            end
        end
    end

    assign lu = ID_EX_MEMREAD && (ID_EX_RD != '0) && lu_match;

    // Memory wait dominates everything, including FLUSH.
    always_comb begin
        stall_fe  = 1'b0;
        bubble_ex = 1'b0;
        stall_be  = 1'b0;
        bubble_wb = 1'b0;
        lu_stall  = 1'b0;
        if (mem_wait) begin
            stall_fe  = 1'b1;
            stall_be  = 1'b1;
            bubble_wb = 1'b1;
        end else if (lu && !FLUSH && (state_q != LU_STALL)) begin
            stall_fe  = 1'b1;
            bubble_ex = 1'b1;
            lu_stall  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = MEM_WAIT;
                end else if (lu_stall) begin
                    state_d = LU_STALL;
                end
            end
            LU_STALL: begin
                state_d = mem_wait ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
                if (DMEM_RSP_VALID) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cnt_lu_d = cnt_lu_q;
        if (CNT_CLR) begin
            cnt_lu_d = '0;
        end else if (bubble_ex && (cnt_lu_q != '1)) begin
            cnt_lu_d = cnt_lu_q + 1'b1;
        end

        cnt_mem_d = cnt_mem_q;
        if (CNT_CLR) begin
            cnt_mem_d = '0;
        end else if (stall_be && (cnt_mem_q != '1)) begin
            cnt_mem_d = cnt_mem_q + 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        // A set on the same edge as a clear must not be lost.
        err_d = err_q;
        if (ERR_CLR) begin
            err_d = 1'b0;
        end
        if (mem_wait && (wait_cnt_q == WAIT_LAST)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            cnt_lu_q   <= '0;
            cnt_mem_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_lu_q   <= cnt_lu_d;
            cnt_mem_q  <= cnt_mem_d;
            err_q      <= err_d;
        end
    end

    assign SEL         = RST_N ? sel_raw : '0;
    assign STALL_FE    = RST_N && stall_fe;
    assign BUBBLE_EX   = RST_N && bubble_ex;
    assign STALL_BE    = RST_N && stall_be;
    assign BUBBLE_WB   = RST_N && bubble_wb;
    assign CNT_LU      = cnt_lu_q;
    assign CNT_MEM     = cnt_mem_q;
    assign ERR_TIMEOUT = err_q;

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Bench for otter_hazard_unit: combinational vector table, directed multi-cycle
// sequences, then random traffic against a behavioural model.
module tb_otter_hazard_unit;

    localparam int NS = 3;
    localparam int AW = 5;
    localparam int CW = 2;
    localparam int TO = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [NS*AW-1:0] rs, if_rs;
    logic [NS-1:0] rs_used, if_used;
    logic [AW-1:0] idex_rd, exm_rd, mwb_rd;
    logic idex_mr, exm_rw, exm_mr, mwb_rw, dvalid, flush, err_clr, cnt_clr;
    logic [2*NS-1:0] sel;
    logic stall_fe, bubble_ex, stall_be, bubble_wb, err;
    logic [CW-1:0] cnt_lu, cnt_mem;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [NS*AW-1:0] rs;
        logic [NS-1:0]    used;
        logic [NS*AW-1:0] if_rs;
        logic [NS-1:0]    if_used;
        logic [AW-1:0]    idex_rd;
        logic             idex_mr;
        logic [AW-1:0]    exm_rd;
        logic             exm_rw;
        logic             exm_mr;
        logic [AW-1:0]    mwb_rd;
        logic             mwb_rw;
        logic             dvalid;
        logic             flush;
        logic [2*NS-1:0]  sel;
        logic [3:0]       ctl;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    otter_hazard_unit #(
        .NUM_SRC(NS),
        .ADDR_W (AW),
        .CNT_W  (CW),
        .TIMEOUT(TO)
    ) dut (
        .CLK            (clk),
        .RST_N          (rst_n),
        .RS             (rs),
        .RS_USED        (rs_used),
        .IF_ID_RS       (if_rs),
        .IF_ID_RS_USED  (if_used),
        .ID_EX_RD       (idex_rd),
        .ID_EX_MEMREAD  (idex_mr),
        .EX_MEM_RD      (exm_rd),
        .EX_MEM_REGWRITE(exm_rw),
        .EX_MEM_MEMREAD (exm_mr),
        .MEM_WB_RD      (mwb_rd),
        .MEM_WB_REGWRITE(mwb_rw),
        .DMEM_RSP_VALID (dvalid),
        .FLUSH          (flush),
        .ERR_CLR        (err_clr),
        .CNT_CLR        (cnt_clr),
        .SEL            (sel),
        .STALL_FE       (stall_fe),
        .BUBBLE_EX      (bubble_ex),
        .STALL_BE       (stall_be),
        .BUBBLE_WB      (bubble_wb),
        .CNT_LU         (cnt_lu),
        .CNT_MEM        (cnt_mem),
        .ERR_TIMEOUT    (err)
    );

    function automatic logic [3:0] ctl();
        return {stall_fe, bubble_ex, stall_be, bubble_wb};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs = '0; rs_used = '0; if_rs = '0; if_used = '0;
        idex_rd = '0; idex_mr = 0; exm_rd = '0; exm_rw = 0; exm_mr = 0;
        mwb_rd = '0; mwb_rw = 0; dvalid = 0; flush = 0; err_clr = 0; cnt_clr = 0;
    endtask

    task automatic set_lu();
        idex_mr = 1; idex_rd = 5'd7; if_rs = {5'd0, 5'd7, 5'd0}; if_used = 3'b010;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic apply_vec(input vec_t v);
        rs = v.rs; rs_used = v.used; if_rs = v.if_rs; if_used = v.if_used;
        idex_rd = v.idex_rd; idex_mr = v.idex_mr; exm_rd = v.exm_rd; exm_rw = v.exm_rw;
        exm_mr = v.exm_mr; mwb_rd = v.mwb_rd; mwb_rw = v.mwb_rw; dvalid = v.dvalid;
        flush = v.flush; err_clr = 0; cnt_clr = 0;
    endtask

    task automatic build_table();
        vec_t v;
        // forwarding
        v = '0; v.rs = {5'd0, 5'd0, 5'd5}; v.used = 3'b011; v.exm_rd = 5; v.exm_rw = 1;
        v.mwb_rd = 5; v.mwb_rw = 1; v.sel = 6'b00_00_01; vecs.push_back(v);
        v.exm_rw = 0; v.sel = 6'b00_00_10; vecs.push_back(v);
        v = '0; v.used = 3'b111; v.exm_rw = 1; v.mwb_rw = 1; vecs.push_back(v);
        v = '0; v.rs = {5'd9, 5'd9, 5'd5}; v.exm_rd = 9; v.exm_rw = 1; v.mwb_rd = 5;
        v.mwb_rw = 1; vecs.push_back(v);
        v = '0; v.rs = {5'd9, 5'd9, 5'd5}; v.used = 3'b110; v.exm_rd = 9; v.mwb_rd = 9;
        v.mwb_rw = 1; v.sel = 6'b10_10_00; vecs.push_back(v);
        v = '0; v.rs = {5'd9, 5'd3, 5'd5}; v.used = 3'b111; v.exm_rd = 3; v.exm_rw = 1;
        v.mwb_rd = 9; v.mwb_rw = 1; v.sel = 6'b10_01_00; vecs.push_back(v);
        // load-use
        v = '0; v.if_rs = {5'd0, 5'd7, 5'd0}; v.if_used = 3'b010; v.idex_rd = 7;
        v.idex_mr = 1; v.ctl = 4'b1100; vecs.push_back(v);
        v.if_used = 3'b101; v.ctl = 4'b0000; vecs.push_back(v);
        v = '0; v.if_used = 3'b111; v.idex_mr = 1; vecs.push_back(v);
        v = '0; v.if_rs = {5'd0, 5'd7, 5'd0}; v.if_used = 3'b010; v.idex_rd = 7;
        v.idex_mr = 1; v.flush = 1; vecs.push_back(v);
        v.flush = 0; v.idex_mr = 0; vecs.push_back(v);
        // memory wait
        v = '0; v.exm_mr = 1; v.ctl = 4'b1011; vecs.push_back(v);
        v.if_rs = {5'd0, 5'd7, 5'd0}; v.if_used = 3'b010; v.idex_rd = 7; v.idex_mr = 1;
        v.flush = 1; vecs.push_back(v);
        v.flush = 0; v.dvalid = 1; v.ctl = 4'b1100; vecs.push_back(v);
        v = '0; v.if_rs = {5'd7, 5'd0, 5'd0}; v.if_used = 3'b100; v.idex_rd = 7;
        v.idex_mr = 1; v.ctl = 4'b1100; vecs.push_back(v);
    endtask

    // Behavioural model state.
    int m_cnt_lu, m_cnt_mem, m_run;
    bit m_err, m_waiting, m_after_lu;

    task automatic model_reset();
        m_cnt_lu = 0; m_cnt_mem = 0; m_run = 0;
        m_err = 0; m_waiting = 0; m_after_lu = 0;
    endtask

    task automatic model_comb(output logic [2*NS-1:0] e_sel, output logic [3:0] e_ctl);
        bit hit, lu, mw;
        e_sel = '0;
        for (int n = 0; n < NS; n++) begin
            int r;
            r = int'(rs[n*AW +: AW]);
            if (rs_used[n] && exm_rw && exm_rd != 0 && int'(exm_rd) == r) e_sel[2*n +: 2] = 2'd1;
            else if (rs_used[n] && mwb_rw && mwb_rd != 0 && int'(mwb_rd) == r)
                e_sel[2*n +: 2] = 2'd2;
        end
        hit = 0;
        for (int n = 0; n < NS; n++)
            if (if_used[n] && if_rs[n*AW +: AW] == idex_rd) hit = 1;
        lu = idex_mr && idex_rd != 0 && hit;
        mw = exm_mr && !dvalid;
        if (mw) e_ctl = 4'b1011;
        else if (lu && !flush && !m_after_lu) e_ctl = 4'b1100;
        else e_ctl = 4'b0000;
    endtask

    task automatic model_edge(input logic [3:0] e_ctl);
        bit mw;
        mw = e_ctl[1];
        if (cnt_clr) m_cnt_lu = 0;
        else if (e_ctl[2] && m_cnt_lu < CMAX) m_cnt_lu++;
        if (cnt_clr) m_cnt_mem = 0;
        else if (mw && m_cnt_mem < CMAX) m_cnt_mem++;
        m_run = mw ? m_run + 1 : 0;
        if (err_clr) m_err = 0;
        if (mw && m_run == TO) m_err = 1;
        m_after_lu = !m_waiting && e_ctl[2];
        m_waiting = mw || (m_waiting && !dvalid);
    endtask

    initial begin
        logic [2*NS-1:0] e_sel;
        logic [3:0] e_ctl;
        clear_inputs();
        rst_n = 0;
        #3;
        chk("reset_sel", 32'(sel), 0);
        chk("reset_ctl", 32'(ctl()), 0);
        chk("reset_cnt", {cnt_lu, cnt_mem, err}, 0);
        do_reset();

        // Table: each vector seen right after a reset pulse, so state is RUN.
        build_table();
        foreach (vecs[i]) begin
            tick();
            rst_n = 0;
            #1;
            rst_n = 1;
            apply_vec(vecs[i]);
            #1;
            chk($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].ctl));
        end
        do_reset();

        // Load-use: one bubble, then suppressed; forwarding from WB afterwards.
        set_lu();
        #1 chk("lu_first", 32'(ctl()), 32'b1100);
        tick();
        rs = {5'd0, 5'd0, 5'd7}; rs_used = 3'b001; mwb_rd = 7; mwb_rw = 1;
        #1 chk("lu_second", 32'(ctl()), 0);
        chk("lu_fwd_wb", 32'(sel), 32'b000010);
        chk("lu_cnt", 32'(cnt_lu), 1);
        tick();
        flush = 1;
        #1 chk("lu_flush", 32'(ctl()), 0);
        tick();
        chk("lu_flush_cnt", 32'(cnt_lu), 1);
        flush = 0;
        #1 chk("lu_after_flush", 32'(ctl()), 32'b1100);
        tick();
        chk("lu_cnt2", 32'(cnt_lu), 2);

        // Memory wait of three cycles.
        clear_inputs();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        exm_mr = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("mw_cycle%0d", i), 32'(ctl()), 32'b1011);
            tick();
        end
        dvalid = 1;
        #1 chk("mw_release", 32'(ctl()), 0);
        tick();
        chk("mw_cnt", 32'(cnt_mem), 3);
        clear_inputs();
        set_lu();
        #1 chk("mw_run_lu", 32'(ctl()), 32'b1100);
        tick();
        #1 chk("mw_run_suppress", 32'(ctl()), 0);
        tick();

        // Overlapping memory wait and load-use.
        clear_inputs();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        set_lu();
        exm_mr = 1;
        for (int i = 0; i < 2; i++) begin
            #1 chk($sformatf("ovl_cycle%0d", i), 32'(ctl()), 32'b1011);
            tick();
        end
        chk("ovl_cnt_lu", 32'(cnt_lu), 0);
        chk("ovl_cnt_mem", 32'(cnt_mem), 2);

        // Watchdog.
        clear_inputs();
        err_clr = 1;
        tick();
        err_clr = 0;
        exm_mr = 1;
        repeat (3) tick();
        chk("to_not_yet", 32'(err), 0);
        tick();
        chk("to_set", 32'(err), 1);
        dvalid = 1;
        tick();
        chk("to_sticky", 32'(err), 1);
        clear_inputs();
        tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("to_clear", 32'(err), 0);
        exm_mr = 1;
        repeat (3) tick();
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("to_set_wins", 32'(err), 1);
        chk("to_cnt_sat", 32'(cnt_mem), CMAX);

        // Saturation and asynchronous reset mid-wait.
        clear_inputs();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        exm_mr = 1;
        rs = {5'd0, 5'd0, 5'd3}; rs_used = 3'b001; exm_rd = 3; exm_rw = 1;
        repeat (5) tick();
        chk("sat_cnt_mem", 32'(cnt_mem), CMAX);
        #2 rst_n = 0;
        #1;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ctl", 32'(ctl()), 0);
        chk("rst_regs", {cnt_lu, cnt_mem, err}, 0);
        tick();
        rst_n = 1;
        clear_inputs();
        set_lu();
        #1 chk("rst_run_lu", 32'(ctl()), 32'b1100);
        tick();
        #1 chk("rst_run_suppress", 32'(ctl()), 0);

        // Clear concurrent with an increment.
        clear_inputs();
        exm_mr = 1;
        tick();
        tick();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("clr_wins", 32'(cnt_mem), 0);

        // Random traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < NS; n++) begin
                rs[n*AW +: AW] = AW'($urandom_range(0, 3));
                if_rs[n*AW +: AW] = AW'($urandom_range(0, 3));
            end
            rs_used = NS'($urandom);
            if_used = NS'($urandom);
            idex_rd = AW'($urandom_range(0, 3));
            exm_rd = AW'($urandom_range(0, 3));
            mwb_rd = AW'($urandom_range(0, 3));
            idex_mr = 1'($urandom);
            exm_rw = 1'($urandom);
            mwb_rw = 1'($urandom);
            exm_mr = ($urandom_range(0, 9) < 6);
            dvalid = ($urandom_range(0, 9) < 3);
            flush = ($urandom_range(0, 7) == 0);
            err_clr = ($urandom_range(0, 15) == 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            #1;
            model_comb(e_sel, e_ctl);
            chk("rnd_sel", 32'(sel), 32'(e_sel));
            chk("rnd_ctl", 32'(ctl()), 32'(e_ctl));
            chk("rnd_cnt_lu", 32'(cnt_lu), 32'(m_cnt_lu));
            chk("rnd_cnt_mem", 32'(cnt_mem), 32'(m_cnt_mem));
            chk("rnd_err", 32'(err), 32'(m_err));
            model_edge(e_ctl);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
